wrr_arb_burst: RTL
==================

# wrr_arb_burst

Weighted round-robin arbiter with burst (packet) lock-in for `NumIn` requesters and one shared output port. Each winner keeps the output for a whole burst, delimited by `last`. Each input keeps top priority for up to `weight` consecutive bursts before priority moves on. It sits in front of shared interconnect ports, where several masters issue multi-beat transfers and need programmable bandwidth shares.

## Interface
- `NumIn`, 8: number of requesters; any value ≥2, not restricted to powers of two.
- `DataWidth`, 32: payload width; unused if `DataType` is overridden.
- `DataType`, `logic [DataWidth-1:0]`: payload type.
- `WeightWidth`, 4: width of each per-input weight and of the credit counter.
- `IdxWidth`, `$clog2(NumIn)`: derived, do not override.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of all arbiter state.
- `weight_i`  in  NumIn×WeightWidth  per-input burst quota; value 0 is treated as 1.
- `req_i`  in  NumIn  per-input valid.
- `last_i`  in  NumIn  per-input end-of-burst flag, qualified by `req_i`.
- `data_i`  in  NumIn×DataType  per-input payload.
- `gnt_o`  out  NumIn  per-input ready; one-hot or zero.
- `req_o`  out  1  output valid.
- `gnt_i`  in  1  output ready.
- `data_o`  out  DataType  payload of the selected input.
- `last_o`  out  1  `last_i` of the selected input.
- `idx_o`  out  IdxWidth  index of the selected input.
- `locked_o`  out  1  selection is frozen (burst lock or stall lock).

## Operation
- **State registers**
  - `ptr_q`: priority pointer.
  - `owner_q`: locked index.
  - `credit_q`: remaining bursts; 0 means fresh.
  - `burst_q`: mid-burst lock.
  - `stall_q`: stall lock.
- **Unlocked selection** (`burst_q|stall_q` = 0):
  - `sel` = first `i` with `req_i[i]` = 1, scanning `ptr_q`, `ptr_q+1`, …, `NumIn-1`, 0, … (wrap).
  - `req_o` = `|req_i`.
  - With no request: `sel` = `ptr_q`.
- **Locked selection**:
  - `sel` = `owner_q`; `req_o` = `req_i[owner_q]`.
  - Other inputs are never granted, even if the owner deasserts `req_i` mid-burst (bubble: `req_o` = 0, `gnt_o` = 0).
- **Outputs**: `idx_o` = `sel`, `data_o` = `data_i[sel]`, `last_o` = `last_i[sel]`, `gnt_o[sel]` = `gnt_i & req_o`, all other bits 0.
- **Transfer** = `req_o & gnt_i`. Lock state updates:
  - `req_o & !gnt_i` → `stall_q` ← 1, `owner_q` ← `sel`.
  - Transfer with `last_o` = 0 → `burst_q` ← 1, `stall_q` ← 0, `owner_q` ← `sel`.
  - Transfer with `last_o` = 1 → `burst_q` ← 0, `stall_q` ← 0.
- **Credits**, evaluated on a transfer with `last_o` = 1:
  - `ec` = `credit_q` if (`sel` == `ptr_q` and `credit_q` ≠ 0); otherwise `max(weight_i[sel], 1)`.
  - `rem` = `ec - 1`.
  - `rem` = 0 → `ptr_q` ← (`sel` == `NumIn-1`) ? 0 : `sel+1`, and `credit_q` ← 0.
  - `rem` ≠ 0 → `ptr_q` ← `sel`, `credit_q` ← `rem`.
- **Weight sampling**: `weight_i` is read only at fresh loads. Changing it mid-quota takes effect at the next fresh load.
- **Arithmetic**: credit arithmetic is `WeightWidth` bits wide and never underflows, because `ec` ≥ 1.
- **Upstream rules** (checked by bench assertions):
  - Once `gnt_o[i]` is withheld while `req_i[i]` = 1, `req_i[i]`, `data_i[i]` and `last_i[i]` must stay stable until granted.
  - `gnt_o` is one-hot or zero.
  - `gnt_o` ≠ 0 implies `gnt_i`.
- **Flush**: `flush_i` = 1 at a clock edge → all state registers take their reset values, regardless of other inputs, including mid-burst.

## Timing
- **Latency**:
  - `req_i`/`data_i`/`last_i` → outputs: combinational, 0 cycles.
  - `gnt_i` → `gnt_o`: combinational.
  - State takes effect in the cycle after the deciding edge.
- **Reset values**: `ptr_q`, `owner_q`, `credit_q` = 0; `burst_q`, `stall_q` = 0.
- **Outputs in reset with `req_i` = 0**: `req_o` = 0, `gnt_o` = 0, `idx_o` = 0, `locked_o` = 0, `data_o` = `data_i[0]`, `last_o` = `last_i[0]`.
- **Throughput**: one beat per cycle, including back-to-back bursts from different inputs. There is no dead cycle at a burst boundary.
- **Simultaneous events**:
  - `flush_i` has priority over any transfer in the same cycle.
  - A single-beat burst (`last` = 1 on the first beat) never sets `burst_q`.

## Test plan
1. **Reset/idle**: hold `rst_ni` low, then release with `req_i` = 0 → `req_o` = 0, `gnt_o` = 0, `idx_o` = 0, `locked_o` = 0.
2. **Equal weights**: `NumIn` = 5, all weights 1, `req_i` = 5'h1F, `last_i` = all 1, `gnt_i` = 1 → `idx_o` = 0,1,2,3,4,0,1 on consecutive cycles (wrap at a non-power-of-two count).
3. **Weighted**: `NumIn` = 4, weights {3,1,0,1}, all inputs requesting single beats, `gnt_i` = 1 → `idx_o` = 0,0,0,1,2,3,0,0,0 (weight 0 acts as 1).
4. **Burst lock**:
   - Input 2 sends a 4-beat burst (`last` on beat 4); input 0 requests throughout.
   - Input 2 deasserts `req` for 2 cycles after beat 2 → `idx_o` = 2 throughout, `req_o` = 0 during the gap, `gnt_o[0]` never 1.
   - `locked_o` = 1 from beat 1 until beat 4 completes; input 0 is granted in the next cycle.
5. **Stall lock**: input 3 is selected with `gnt_i` = 0 for 3 cycles while input 0 raises `req` → `idx_o` stays 3 and `locked_o` = 1. On `gnt_i` = 1, input 3 transfers.
6. **Flush mid-burst**: after beat 2 of input 1's burst, pulse `flush_i` for 1 cycle with `req_i` = 4'b0011 → next cycle `locked_o` = 0, `idx_o` = 0, `credit_q` = 0.

Source files
------------

// File: rtl/wrr_arb_burst_if.sv
// Request/grant bundle between the upstream requesters, the arbiter and the shared output port.
// Valid/ready: a beat moves on an edge where valid (req) and ready (gnt) are both high.
// Once a valid beat is withheld, its req, data and last stay stable until that beat moves.
interface wrr_arb_burst_if #(
  parameter int  NumIn    = 8,
  parameter int  IdxWidth = $clog2(NumIn),
  parameter type DataType = logic [31:0]
);
  logic [NumIn-1:0]    req_i;
  logic [NumIn-1:0]    last_i;
  DataType             data_i [NumIn];
  logic [NumIn-1:0]    gnt_o;
  logic                req_o;
  logic                gnt_i;
  DataType             data_o;
  logic                last_o;
  logic [IdxWidth-1:0] idx_o;
  logic                locked_o;

  modport slave (
    input  req_i, last_i, data_i, gnt_i,
    output gnt_o, req_o, data_o, last_o, idx_o, locked_o
  );

  modport master (
    output req_i, last_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o, last_o, idx_o, locked_o
  );
endinterface

// File: rtl/wrr_arb_burst.sv
// Weighted round-robin arbiter with burst lock-in: a winner holds the output until its last beat,
// and an input keeps top priority for up to weight consecutive bursts.
module wrr_arb_burst #(
  parameter int  NumIn       = 8,
  parameter int  DataWidth   = 32,
  parameter type DataType    = logic [DataWidth-1:0],
  parameter int  WeightWidth = 4,
  parameter int  IdxWidth    = $clog2(NumIn)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
  wrr_arb_burst_if.slave                    bus,
  output logic [1:0]                        dbg_lock_o,
  output logic [IdxWidth-1:0]               dbg_ptr_o,
  output logic [WeightWidth-1:0]            dbg_credit_o
);

  // Bit 1 is the mid-burst lock, bit 0 the stall lock; both can be set at once.
  typedef enum logic [1:0] {
    LK_NONE  = 2'b00,
    LK_STALL = 2'b01,
    LK_BURST = 2'b10,
    LK_BOTH  = 2'b11
  } lock_e;

  lock_e                  lock_q, lock_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [WeightWidth-1:0] credit_q, credit_d;
  logic [IdxWidth-1:0]    rr_sel, sel, cand;
  logic [WeightWidth-1:0] w_sel, ec, rem;
  logic                   locked, out_req, xfer, out_last, rr_found;
  DataType                data_sel;
  int                     j;

  assign locked = (lock_q != LK_NONE);

  // Circular scan starting at ptr_q; falls back to ptr_q when nobody requests.
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    j        = 0;
    cand     = '0;
    for (int k = 0; k < NumIn; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NumIn) j = j - NumIn;
      cand = IdxWidth'(j);
      if (!rr_found && bus.req_i[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign sel      = locked ? owner_q : rr_sel;
  assign out_req  = locked ? bus.req_i[owner_q] : |bus.req_i;
  assign xfer     = out_req & bus.gnt_i;
  assign out_last = bus.last_i[sel];
  assign data_sel = bus.data_i[sel];

  always_comb begin
    bus.gnt_o      = '0;
    bus.gnt_o[sel] = xfer;
  end

  assign bus.req_o    = out_req;
  assign bus.data_o   = data_sel;
  assign bus.last_o   = out_last;
  assign bus.idx_o    = sel;
  assign bus.locked_o = locked;

  // A stored credit only applies while the pointer still sits on the winner; otherwise load fresh.
  assign w_sel = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];
  assign ec    = (sel == ptr_q && credit_q != '0) ? credit_q : w_sel;
  assign rem   = ec - WeightWidth'(1);

  always_comb begin
    lock_d   = lock_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    if (out_req && !bus.gnt_i) begin
      lock_d  = (lock_q inside {LK_BURST, LK_BOTH}) ? LK_BOTH : LK_STALL;
      owner_d = sel;
    end else if (xfer && !out_last) begin
      lock_d  = LK_BURST;
      owner_d = sel;
    end else if (xfer) begin
      lock_d = LK_NONE;
      if (rem == '0) begin
        ptr_d    = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + IdxWidth'(1);
        credit_d = '0;
      end else begin
        ptr_d    = sel;
        credit_d = rem;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q   <= LK_NONE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else if (flush_i) begin
      lock_q   <= LK_NONE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      lock_q   <= lock_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  assign dbg_lock_o   = lock_q;
  assign dbg_ptr_o    = ptr_q;
  assign dbg_credit_o = credit_q;

endmodule
